// File: rtl/digital_tube_pkg.sv
// Shared constants for the seven-segment scan driver: register map, CTRL layout,
// reset values and the hex-to-segment table.
package digital_tube_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_CTRL      = 3'd1;
  localparam logic [2:0] ADDR_SCAN_DIV  = 3'd2;
  localparam logic [2:0] ADDR_BLINK_DIV = 3'd3;
  localparam logic [2:0] ADDR_STATUS    = 3'd4;

  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_BLINK_BIT = 1;
  localparam int unsigned CTRL_LZ_BIT    = 2;
  localparam int unsigned CTRL_DP_LSB    = 8;

  localparam int unsigned SCAN_DIV_RST  = 49999;
  localparam logic [7:0]  BLINK_DIV_RST = 8'd99;

  // Active-high gfedcba patterns, entry 0 in the low bits.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef struct packed {
    logic [7:0] dp;
    logic       lz_blank;
    logic       blink_en;
    logic       enable;
  } ctrl_t;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/digital_tube_scan_timer.sv
// Scan timebase: per-slot prescaler, digit index, frame counter and blink phase.
// Everything is held at zero while the display is disabled.
module digital_tube_scan_timer
  import digital_tube_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic             i_clr_presc,
  input  logic [DIV_W-1:0] i_scan_div,
  input  logic [7:0]       i_blink_div,
  output logic [2:0]       o_idx,
  output logic             o_phase,
  output logic             o_slot_end,
  output logic             o_frame_end
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

  logic [DIV_W-1:0] r_presc;
  logic [2:0]       r_idx;
  logic [7:0]       r_frame;
  logic             r_phase;

  assign o_slot_end  = i_enable && (r_presc == i_scan_div);
  assign o_frame_end = o_slot_end && (r_idx == LAST_IDX);
  assign o_idx       = r_idx;
  assign o_phase     = r_phase;

  always_ff @(posedge clk) begin
    if (rst || !i_enable) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_frame <= '0;
      r_phase <= 1'b0;
    end else if (i_clr_presc) begin
      r_presc <= '0;
    end else if (o_slot_end) begin
      r_presc <= '0;
      if (o_frame_end) begin
        r_idx <= '0;
        if (r_frame == i_blink_div) begin
          r_frame <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_frame <= r_frame + 8'd1;
        end
      end else begin
        r_idx <= r_idx + 3'd1;
      end
    end else begin
      r_presc <= r_presc + DIV_W'(1);
    end
  end

endmodule

// File: rtl/digital_tube_scan_avalon.sv
// Avalon-MM slave plus multiplexed seven-segment driver: register file, tear-free
// digit buffer, blanking and segment decode with registered pin outputs.
module digital_tube_scan_avalon
  import digital_tube_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 6,
  parameter int unsigned DIV_W       = 16,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          DIG_ACT_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [2:0]            address,
  input  logic [3:0]            byteenable,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] dig
);

  localparam int unsigned DATA_W = 4 * NUM_DIGITS;

  logic [DATA_W-1:0] r_pend_data;
  logic [DATA_W-1:0] r_disp_data;
  logic              r_pend;
  ctrl_t             r_ctrl;
  logic [DIV_W-1:0]  r_scan_div;
  logic [7:0]        r_blink_div;

  logic w_wr, w_rd, w_xfer, w_phase, w_slot_end, w_frame_end;
  logic [2:0]  w_idx;
  logic [31:0] w_ctrl_word, w_data_new, w_ctrl_new, w_scan_new, w_blink_new, w_rd_mux;
  logic        w_unused;

  assign w_wr = chipselect && !write_n;
  assign w_rd = chipselect && write_n;

  digital_tube_scan_timer #(
    .NUM_DIGITS(NUM_DIGITS),
    .DIV_W     (DIV_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_enable   (r_ctrl.enable),
    .i_clr_presc(w_wr && (address == ADDR_SCAN_DIV)),
    .i_scan_div (r_scan_div),
    .i_blink_div(r_blink_div),
    .o_idx      (w_idx),
    .o_phase    (w_phase),
    .o_slot_end (w_slot_end),
    .o_frame_end(w_frame_end)
  );

  assign w_ctrl_word = {16'h0, r_ctrl.dp, 5'b0, r_ctrl.lz_blank, r_ctrl.blink_en, r_ctrl.enable};
  assign w_data_new  = be_merge(32'(r_pend_data), writedata, byteenable);
  assign w_ctrl_new  = be_merge(w_ctrl_word, writedata, byteenable);
  assign w_scan_new  = be_merge(32'(r_scan_div), writedata, byteenable);
  assign w_blink_new = be_merge({24'h0, r_blink_div}, writedata, byteenable);
  assign w_unused    = ^{w_data_new, w_ctrl_new, w_scan_new, w_blink_new, w_slot_end};

  // While disabled there is no frame boundary to wait for, so hand over at once.
  assign w_xfer = r_pend && (r_ctrl.enable ? w_frame_end : 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_data <= '0;
      r_disp_data <= '0;
      r_pend      <= 1'b0;
      r_ctrl      <= '0;
      r_scan_div  <= DIV_W'(SCAN_DIV_RST);
      r_blink_div <= BLINK_DIV_RST;
    end else begin
      if (w_xfer) begin
        r_disp_data <= r_pend_data;
        r_pend      <= 1'b0;
      end
      // A DATA write in the transfer cycle wins the pending flag back.
      if (w_wr) begin
        case (address)
          ADDR_DATA: begin
            r_pend_data <= w_data_new[DATA_W-1:0];
            r_pend      <= 1'b1;
          end
          ADDR_CTRL: r_ctrl <= '{dp:       w_ctrl_new[CTRL_DP_LSB +: 8],
                                 lz_blank: w_ctrl_new[CTRL_LZ_BIT],
                                 blink_en: w_ctrl_new[CTRL_BLINK_BIT],
                                 enable:   w_ctrl_new[CTRL_EN_BIT]};
          ADDR_SCAN_DIV:  r_scan_div  <= w_scan_new[DIV_W-1:0];
          ADDR_BLINK_DIV: r_blink_div <= w_blink_new[7:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA:      w_rd_mux = 32'(r_pend_data);
      ADDR_CTRL:      w_rd_mux = w_ctrl_word;
      ADDR_SCAN_DIV:  w_rd_mux = 32'(r_scan_div);
      ADDR_BLINK_DIV: w_rd_mux = {24'h0, r_blink_div};
      ADDR_STATUS:    w_rd_mux = {21'h0, w_idx, 6'h0, r_pend, w_phase};
      default:        w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) readdata <= '0;
    else if (w_rd) readdata <= w_rd_mux;
  end

  logic [3:0]            w_nib;
  logic                  w_dp, w_upper_zero, w_blank;
  logic [7:0]            w_seg_on;
  logic [NUM_DIGITS-1:0] w_dig_on;

  always_comb begin
    w_nib        = '0;
    w_dp         = 1'b0;
    w_upper_zero = 1'b1;
    w_dig_on     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_idx == 3'(i)) begin
        w_nib       = r_disp_data[4*i +: 4];
        w_dp        = r_ctrl.dp[i];
        w_dig_on[i] = r_ctrl.enable;
      end
      if ((3'(i) >= w_idx) && (r_disp_data[4*i +: 4] != 4'h0)) w_upper_zero = 1'b0;
    end
    w_blank  = (r_ctrl.blink_en && w_phase) ||
               (r_ctrl.lz_blank && w_upper_zero && (w_idx != 3'd0));
    w_seg_on = (!r_ctrl.enable || w_blank) ? 8'h00 : {w_dp, HEX_SEG[w_nib]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_ACT_LOW ? 8'hFF : 8'h00;
      dig <= DIG_ACT_LOW ? '1 : '0;
    end else begin
      seg <= SEG_ACT_LOW ? ~w_seg_on : w_seg_on;
      dig <= DIG_ACT_LOW ? ~w_dig_on : w_dig_on;
    end
  end

endmodule
